// File: rtl/heat_grid_pkg.sv
// Shared definitions for the heat-grid timestep sequencer: default sizes and FSM state encoding.
package heat_grid_pkg;

  localparam int unsigned NColsDefault      = 8;
  localparam int unsigned IterWDefault      = 16;
  localparam int unsigned AckTimeoutDefault = 64;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitAll = 3'd1,
    StStart   = 3'd2,
    StError   = 3'd3,
    StDone    = 3'd4
  } sync_state_e;

endpackage

// File: rtl/flag_reduce.sv
// Registered AND/NOR reduction of the per-column done flags; adds one cycle of latency.
module flag_reduce
  import heat_grid_pkg::*;
#(
  parameter int unsigned NCOLS = NColsDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NCOLS-1:0] col_flag_i,
  output logic             all_set_o,
  output logic             all_clr_o
);

  logic all_set_q;
  logic all_clr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      all_set_q <= 1'b0;
      all_clr_q <= 1'b0;
    end else begin
      all_set_q <= &col_flag_i;
      all_clr_q <= ~|col_flag_i;
    end
  end

  assign all_set_o = all_set_q;
  assign all_clr_o = all_clr_q;

endmodule

// File: rtl/heat_grid_sync_ctrl.sv
// Global timestep sequencer: waits for all column done flags, broadcasts start, counts steps.
// Optional SYNC_STEP_CYCLES_EN adds a step_cycles output reporting cycles per timestep.
module heat_grid_sync_ctrl
  import heat_grid_pkg::*;
#(
  parameter int unsigned NCOLS       = NColsDefault,
  parameter int unsigned ITER_W      = IterWDefault,
  parameter int unsigned ACK_TIMEOUT = AckTimeoutDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ITER_W-1:0] max_iter,
  input  logic [NCOLS-1:0]  col_flag,
`ifdef SYNC_STEP_CYCLES_EN
  output logic [31:0]       step_cycles,
`endif
  output logic              start,
  output logic [ITER_W-1:0] iter_count,
  output logic              step_tick,
  output logic              busy,
  output logic              done,
  output logic              ack_err
);

  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(ACK_TIMEOUT);

  sync_state_e       state_q;
  logic              start_q, tick_q, busy_q, done_q, err_q;
  logic [ITER_W-1:0] iter_q, limit_q, iter_nxt;
  logic [TmoW-1:0]   tmo_q;
  logic              all_set, all_clr;

  flag_reduce #(
    .NCOLS(NCOLS)
  ) u_flag_reduce (
    .clk_i     (clk),
    .rst_ni    (reset),
    .col_flag_i(col_flag),
    .all_set_o (all_set),
    .all_clr_o (all_clr)
  );

  assign iter_nxt = iter_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      iter_q  <= '0;
      limit_q <= '0;
      tmo_q   <= '0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StWaitAll;
            limit_q <= max_iter;
            iter_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        StWaitAll: begin
          if (all_set) begin
            tick_q <= 1'b1;
            iter_q <= iter_nxt;
            if (limit_q != '0 && iter_nxt == limit_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (!run) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StStart;
              tmo_q   <= '0;
            end
          end
        end
        StStart: begin
          start_q <= 1'b1;
          tmo_q   <= tmo_q + 1'b1;
          // Only a clear seen while start is already up counts as the acknowledge.
          if (start_q && all_clr) begin
            start_q <= 1'b0;
            state_q <= StWaitAll;
          end else if (tmo_q == TmoLimit) begin
            start_q <= 1'b0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StError;
          end
        end
        StError: begin
          start_q <= 1'b0;
        end
        StDone: begin
          if (!run) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SYNC_STEP_CYCLES_EN
  logic [31:0] cyc_q, step_cycles_q;
  logic        tick_now;

  assign tick_now = (state_q == StWaitAll) && all_set;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_q         <= '0;
      step_cycles_q <= '0;
    end else if (state_q == StIdle && run) begin
      cyc_q <= 32'd1;
    end else if (tick_now) begin
      step_cycles_q <= cyc_q;
      cyc_q         <= 32'd1;
    end else if ((state_q == StWaitAll || state_q == StStart) && cyc_q != '1) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign step_cycles = step_cycles_q;
`endif

  assign start      = start_q;
  assign iter_count = iter_q;
  assign step_tick  = tick_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ack_err    = err_q;

endmodule

// File: tb/tb_heat_grid_sync_ctrl.sv
// Scoreboard bench for heat_grid_sync_ctrl: bench plays the column engines with random timing.
module tb_heat_grid_sync_ctrl;

  localparam int unsigned NCOLS       = 4;
  localparam int unsigned ITER_W      = 4;
  localparam int unsigned ACK_TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              run = 1'b0;
  logic [ITER_W-1:0] max_iter = '0;
  logic [NCOLS-1:0]  col_flag = '0;
  logic              start, step_tick, busy, done, ack_err;
  logic [ITER_W-1:0] iter_count;
`ifdef SYNC_STEP_CYCLES_EN
  logic [31:0]       step_cycles;
`endif

  heat_grid_sync_ctrl #(
    .NCOLS      (NCOLS),
    .ITER_W     (ITER_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
`ifdef SYNC_STEP_CYCLES_EN
    .step_cycles(step_cycles),
`endif
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .max_iter  (max_iter),
    .col_flag  (col_flag),
    .start     (start),
    .iter_count(iter_count),
    .step_tick (step_tick),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Expected event cycles (and tick values) queued by the stimulus side.
  int tick_cyc_q[$];
  int tick_val_q[$];
  int rise_q[$];
  int fall_q[$];

  logic start_prev = 1'b0;
  int   exp_c, exp_v;

  always @(negedge clk) begin
    if (step_tick === 1'b1) begin
      if (tick_cyc_q.size() == 0) check("unexpected_tick_queue", tick_cyc_q.size(), 1);
      else begin
        exp_c = tick_cyc_q.pop_front();
        exp_v = tick_val_q.pop_front();
        check("tick_cycle", cyc, exp_c);
        check("tick_iter_count", iter_count, exp_v);
      end
    end
    if (start === 1'b1 && start_prev == 1'b0) begin
      if (rise_q.size() == 0) check("unexpected_start_rise_queue", rise_q.size(), 1);
      else check("start_rise_cycle", cyc, rise_q.pop_front());
    end
    if (start === 1'b0 && start_prev == 1'b1) begin
      if (fall_q.size() == 0) check("unexpected_start_fall_queue", fall_q.size(), 1);
      else check("start_fall_cycle", cyc, fall_q.pop_front());
    end
    start_prev = (start === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input logic lvl);
    int k = 0;
    while (start !== lvl && k < 40) begin
      tick(1);
      k++;
    end
    check("wait_start_level", start, lvl);
  endtask

  // Raise all flags, column NCOLS-1 strictly last unless together; returns cycle of last rise.
  task automatic raise_flags(input bit together, output int c_last);
    int d[NCOLS];
    int dmax = 0;
    for (int i = 0; i < NCOLS - 1; i++) begin
      d[i] = together ? 0 : int'($urandom_range(0, 3));
      if (d[i] > dmax) dmax = d[i];
    end
    d[NCOLS-1] = together ? 0 : dmax + 1;
    if (together) dmax = -1;
    c_last = cyc;
    for (int t = 0; t <= dmax + 1; t++) begin
      for (int i = 0; i < NCOLS; i++) if (d[i] == t) col_flag[i] = 1'b1;
      c_last = cyc;
      if (t != dmax + 1) tick(1);
    end
  endtask

  task automatic handshake(input bit drop_run);
    wait_start(1'b1);
    if (drop_run) run = 1'b0;
    tick($urandom_range(0, 3));
    col_flag = '0;
    fall_q.push_back(cyc + 2);
    wait_start(1'b0);
  endtask

  // One timestep: model says tick 2 cycles after last flag, start 1 cycle later unless parked.
  task automatic step(input int n, input int limit, input bit together, input bit drop_run);
    int  c;
    bit  more;
    raise_flags(together, c);
    tick_cyc_q.push_back(c + 2);
    tick_val_q.push_back(n % (1 << ITER_W));
    more = !(limit != 0 && n == limit) && run;
    if (more) begin
      rise_q.push_back(c + 3);
      handshake(drop_run);
    end else begin
      tick(4);
    end
  endtask

  initial begin
    int c;
    // Reset held 3 cycles.
    tick(3);
    check("rst_start", start, 0);
    check("rst_step_tick", step_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_iter_count", iter_count, 0);
    reset = 1'b1;
    tick(3);
    check("idle_busy", busy, 0);
    check("idle_start", start, 0);

    // Three steps with limit 3: first together, then staggered.
    max_iter = 4'd3;
    run = 1'b1;
    tick(1);
    step(1, 3, 1'b1, 1'b0);
    check("busy_after_handshake", busy, 1);
    step(2, 3, 1'b0, 1'b0);
    step(3, 3, 1'b0, 1'b0);
    tick(3);
    check("done_set", done, 1);
    check("done_iter_count", iter_count, 3);
    check("done_busy", busy, 0);
    check("done_no_start", start, 0);
    run = 1'b0;
    col_flag = '0;
    tick(2);
    check("done_cleared", done, 0);
    check("idle_again_busy", busy, 0);

    // Acknowledge timeout: column 2 never drops its flag.
    max_iter = '0;
    run = 1'b1;
    tick(1);
    raise_flags(1'b0, c);
    tick_cyc_q.push_back(c + 2);
    tick_val_q.push_back(1);
    rise_q.push_back(c + 3);
    fall_q.push_back(c + 3 + ACK_TIMEOUT);
    wait_start(1'b1);
    col_flag = 4'b0100;
    tick(ACK_TIMEOUT + 4);
    check("tmo_start", start, 0);
    check("tmo_ack_err", ack_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_done", done, 0);
    tick(5);
    check("tmo_ack_err_sticky", ack_err, 1);
    reset = 1'b0;
    col_flag = '0;
    run = 1'b0;
    tick(2);
    check("rst_clears_ack_err", ack_err, 0);
    check("rst_clears_iter", iter_count, 0);
    reset = 1'b1;
    tick(2);

    // Free-run wrap; flags already high on entry count as step 1 ready.
    col_flag = '1;
    tick(2);
    run = 1'b1;
    c = cyc;
    tick_cyc_q.push_back(c + 2);
    tick_val_q.push_back(1);
    rise_q.push_back(c + 3);
    handshake(1'b0);
    for (int n = 2; n <= (1 << ITER_W) + 1; n++) begin
      if (n == 3) max_iter = 4'd5;
      step(n, 0, 1'b0, n == (1 << ITER_W) + 1);
    end
    check("wrap_no_done", done, 0);
    step((1 << ITER_W) + 2, 0, 1'b0, 1'b0);
    check("parked_busy", busy, 0);
    check("parked_done", done, 0);
    check("parked_start", start, 0);
    check("parked_iter", iter_count, ((1 << ITER_W) + 2) % (1 << ITER_W));

    // Reset in the middle of a handshake.
    col_flag = '0;
    max_iter = '0;
    run = 1'b1;
    tick(1);
    raise_flags(1'b0, c);
    tick_cyc_q.push_back(c + 2);
    tick_val_q.push_back(1);
    rise_q.push_back(c + 3);
    wait_start(1'b1);
    reset = 1'b0;
    fall_q.push_back(cyc + 1);
    tick(2);
    check("midrst_start", start, 0);
    check("midrst_iter", iter_count, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b1;
    run = 1'b0;
    col_flag = '0;
    tick(5);

    check("pending_ticks", tick_cyc_q.size(), 0);
    check("pending_rises", rise_q.size(), 0);
    check("pending_falls", fall_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
